// File: rtl/char_buf_sram_reader.sv
// Character buffer read engine: streams SRAM words as LSB-first byte beats with sop/eop framing.
// Optional CHAR_BUF_READER_FRAME_CNT_EN adds frame_count and a sticky underflow flag.
module char_buf_sram_reader #(
   parameter int unsigned COLS_WORDS   = 20,
   parameter int unsigned ROWS         = 60,
   parameter logic [10:0] BASE_ADDR    = 11'd0,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   output logic [10:0] m_address,
   output logic        m_read,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   output logic [7:0]  st_data,
   output logic        st_valid,
   input  logic        st_ready,
   output logic        st_sop,
   output logic        st_eop,
   output logic        busy
`ifdef CHAR_BUF_READER_FRAME_CNT_EN
   ,
   output logic [15:0] frame_count,
   output logic        underflow
`endif
);
   localparam int unsigned TotalWords = COLS_WORDS * ROWS;
   localparam int unsigned IdxW       = (TotalWords > 1) ? $clog2(TotalWords) : 1;
   localparam int unsigned AW         = $clog2(FIFO_DEPTH);
   localparam logic [IdxW-1:0] LastIdx  = IdxW'(TotalWords - 1);
   localparam logic [12:0]     LastChar = 13'(TotalWords * 4 - 1);
   localparam logic [AW:0]     CntOne   = (AW + 1)'(1);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

   state_e                  state_q;
   logic [IdxW-1:0]         idx_q;
   logic [READ_LATENCY-1:0] lat_q;
   logic [AW:0]             out_q;
   logic [AW:0]             fcnt_q;
   logic [AW-1:0]           wr_ptr_q;
   logic [AW-1:0]           rd_ptr_q;
   logic [31:0]             mem_q [FIFO_DEPTH];
   logic [12:0]             char_cnt_q;

   logic        accept;
   logic        push;
   logic        hs;
   logic        pop;
   logic [AW+1:0] inflight;
   logic [31:0] head;

   // Words in flight plus words buffered never exceed FIFO_DEPTH, so the FIFO cannot overflow.
   assign inflight  = {1'b0, out_q} + {1'b0, fcnt_q};
   assign m_read    = (state_q == StFetch) && (inflight < (AW + 2)'(FIFO_DEPTH));
   assign m_address = BASE_ADDR + 11'(idx_q);
   assign accept    = m_read && !m_waitrequest;
   assign push      = lat_q[READ_LATENCY-1];
   assign busy      = (state_q != StIdle);

   assign head      = mem_q[rd_ptr_q];
   assign st_valid  = (fcnt_q != '0);
   assign st_data   = st_valid ? head[{char_cnt_q[1:0], 3'b000} +: 8] : 8'd0;
   assign st_sop    = st_valid && (char_cnt_q == 13'd0);
   assign st_eop    = st_valid && (char_cnt_q == LastChar);
   assign hs        = st_valid && st_ready;
   assign pop       = hs && (char_cnt_q[1:0] == 2'd3);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               idx_q <= '0;
               if (enable) state_q <= StFetch;
            end
            StFetch: begin
               if (accept) begin
                  if (idx_q == LastIdx) begin
                     idx_q   <= '0;
                     state_q <= StDrain;
                  end else begin
                     idx_q <= idx_q + IdxW'(1);
                  end
               end
            end
            StDrain: begin
               if (hs && st_eop) state_q <= enable ? StFetch : StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Return tagging: reset clears it, so data for reads issued before reset is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lat_q  <= '0;
         out_q  <= '0;
         fcnt_q <= '0;
      end else begin
         lat_q <= READ_LATENCY'({lat_q, accept});
         if (accept && !push) out_q <= out_q + CntOne;
         else if (!accept && push) out_q <= out_q - CntOne;
         if (push && !pop) fcnt_q <= fcnt_q + CntOne;
         else if (!push && pop) fcnt_q <= fcnt_q - CntOne;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         char_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (hs) char_cnt_q <= st_eop ? 13'd0 : char_cnt_q + 13'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= m_readdata;
   end

`ifdef CHAR_BUF_READER_FRAME_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_count <= 16'd0;
         underflow   <= 1'b0;
      end else begin
         if (hs && st_eop) frame_count <= frame_count + 16'd1;
         if (st_ready && !st_valid && (state_q == StFetch)) underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/char_buf_sram_reader.md
Name: char_buf_sram_reader

Overview:
- Read-side engine for the VGA character buffer.
- Acts as an Avalon-MM read master on the character SRAM's second port (2048 x 32-bit words, 11-bit word address).
- Fetches character words in raster order, unpacks each word into four 8-bit character codes, and emits them as an Avalon-ST stream with frame delimiters.
- Feeds the character-to-pixel stage of the VGA subsystem.

Parameters:
- COLS_WORDS, 20, 32-bit words per text row (80 chars / 4).
- ROWS, 60, text rows per frame.
- BASE_ADDR, 11'd0, word address of row 0, column 0.
- READ_LATENCY, 1, fixed cycles from an accepted read to readdata valid (1..3).
- FIFO_DEPTH, 4, word FIFO entries (power of two, 2..16).

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- enable, in, 1: start/continue frame scanning.
- m_address, out, 11: SRAM word address.
- m_read, out, 1: read request.
- m_waitrequest, in, 1: slave stall; the read is accepted only when low.
- m_readdata, in, 32: read data, valid READ_LATENCY cycles after acceptance.
- st_data, out, 8: character code.
- st_valid, out, 1: st_data valid.
- st_ready, in, 1: sink ready.
- st_sop, out, 1: first character of frame.
- st_eop, out, 1: last character of frame.
- busy, out, 1: frame in progress.

Behaviour:
- Reset (async assert, sync release): all outputs 0. FIFO empty. Outstanding count 0. State IDLE. m_address = BASE_ADDR.
- States and transitions:
  - IDLE -> FETCH when enable=1. busy=1 in FETCH and DRAIN.
  - FETCH issues reads for word indices 0..COLS_WORDS*ROWS-1 (1200 by default). Address = BASE_ADDR + index, 11-bit wrap modulo 2048.
  - FETCH -> DRAIN after the last read is accepted.
  - DRAIN -> FETCH at the frame boundary (eop beat handshaked) if enable=1; otherwise DRAIN -> IDLE.
  - Deasserting enable mid-frame does not truncate the frame. The current frame always completes.
- Read issue:
  - m_read=1 only in FETCH, and only when (outstanding + fifo_count) < FIFO_DEPTH. This guarantees the FIFO never overflows.
  - m_address and m_read hold stable while m_waitrequest=1.
  - Outstanding count increments on acceptance, decrements when data returns. Simultaneous increment and decrement nets 0.
- Return path:
  - A READ_LATENCY-deep valid shift register tags returning data.
  - Returned words are pushed into the FIFO in order.
- Unpacking:
  - Bytes are emitted LSB first: [7:0], [15:8], [23:16], [31:24].
  - A 2-bit byte index advances on each st_valid & st_ready. The FIFO pops on the handshake of byte 3.
  - st_valid = FIFO not empty. st_data, st_sop and st_eop hold stable while st_ready=0.
- Frame delimiters:
  - st_sop=1 on byte 0 of word 0.
  - st_eop=1 on byte 3 of the last word.
  - A 13-bit character counter tracks position within the frame and resets on the eop handshake.
- Boundary cases:
  - FIFO empty with st_ready=1: st_valid=0, no bubble state.
  - FIFO full: read issue stalls.
  - Push and pop in the same cycle is legal; count is unchanged.
  - Reset mid-frame discards all in-flight data. Returned data for reads issued before reset is ignored.
  - Next frame restarts at BASE_ADDR with sop.

Optional Feature:
- Macro: CHAR_BUF_READER_FRAME_CNT_EN.
- Defined:
  - Adds output frame_count[15:0], which increments (wraps at 0xFFFF) on each eop handshake.
  - Adds output underflow, a sticky flag set when st_ready=1 and st_valid=0 while in FETCH. It is cleared only by reset.
- Undefined: neither port exists and no counter logic is synthesised.

Test Plan:
- Reset with enable=0:
  - All outputs 0, m_address=0.
  - Release reset, raise enable, st_ready=1, model SRAM latency 1, word[i]=i: first beat st_data=0x00 with st_sop=1.
  - Then 0x00,0x00,0x00 (word 0), 0x01,0x00,0x00,0x00 (word 1), and so on.
  - After 4800 beats, st_eop=1 and the next beat has st_sop=1 at address 0.
- Random st_ready (50%) plus m_waitrequest bursts of 1-5 cycles:
  - Stream equals the reference byte sequence.
  - Outstanding + FIFO never exceeds 4.
  - m_address stable during waitrequest.
- READ_LATENCY=3, FIFO_DEPTH=2: no overflow, data order preserved across 1200 words.
- enable dropped at character 1000: frame finishes with eop at beat 4800, then IDLE, busy=0, no further m_read.
- reset_n asserted mid-frame with 2 reads outstanding:
  - Outputs are 0 immediately (async).
  - After release and enable, the first beat is sop with word 0 data; stale returns are not emitted.
- With CHAR_BUF_READER_FRAME_CNT_EN:
  - frame_count reads 3 after 3 frames.
  - Holding st_ready=1 while m_waitrequest=1 for 10 cycles at frame start sets underflow=1, which stays set.
